// File: rtl/crp16_mem_responder.sv
// CRP16 memory responder: dual-port asynchronous-read RAM with an MMIO page on port B
// (LED register, free-running cycle counter, transmit FIFO drained by valid/ready).
module crp16_mem_responder #(
    parameter int unsigned ADDR_W     = 12,
    parameter logic [7:0]  MMIO_PAGE  = 8'hFF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_a,
    input  logic [15:0] data_a,
    input  logic        wren_a,
    output logic [15:0] q_a,
    input  logic [15:0] address_b,
    input  logic [15:0] data_b,
    input  logic        wren_b,
    output logic [15:0] q_b,
    output logic [15:0] led_out,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    logic [15:0] mem [Depth];
    logic [15:0] fifo [FIFO_DEPTH];

    logic [15:0]     led_q;
    logic [31:0]     cnt_q;
    logic [PtrW-1:0] rd_q, wr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [ADDR_W-1:0] idx_a, idx_b;
    logic [7:0]        off_b;
    logic              mmio_b;
    logic              full, empty, push_req, push_ok, pop;
    logic [15:0]       stat, mmio_rdata;
    logic              unused_a;

    assign idx_a    = address_a[ADDR_W-1:0];
    assign idx_b    = address_b[ADDR_W-1:0];
    assign off_b    = address_b[7:0];
    assign mmio_b   = (address_b[15:8] == MMIO_PAGE);
    assign unused_a = ^address_a[15:ADDR_W];

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = empty ? 16'h0000 : fifo[rd_q];
    assign led_out  = led_q;

    assign push_req = wren_b && mmio_b && (off_b == 8'h04);
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        stat      = 16'h0000;
        stat[0]   = full;
        stat[1]   = empty;
        stat[6:2] = 5'(count_q);
        stat[7]   = ovf_q;
    end

    always_comb begin
        mmio_rdata = 16'h0000;
        case (off_b)
            8'h00:   mmio_rdata = led_q;
            8'h01:   mmio_rdata = cnt_q[15:0];
            8'h02:   mmio_rdata = cnt_q[31:16];
            8'h05:   mmio_rdata = stat;
            default: mmio_rdata = 16'h0000;
        endcase
    end

    assign q_a = mem[idx_a];
    assign q_b = mmio_b ? mmio_rdata : mem[idx_b];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (wren_b && mmio_b && (off_b == 8'h05)) ovf_d = 1'b0;
        if (push_req && full && !pop)             ovf_d = 1'b1;
    end

    // Port B is written last so it wins a same-index collision.
    always_ff @(posedge clock) begin
        if (wren_a)            mem[idx_a] <= data_a;
        if (wren_b && !mmio_b) mem[idx_b] <= data_b;
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo[wr_q] <= data_b;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            led_q   <= 16'h0000;
            cnt_q   <= 32'h0000_0000;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + 32'd1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (wren_b && mmio_b && (off_b == 8'h00)) led_q <= data_b;
            if (push_ok) wr_q <= wr_q + PtrW'(1);
            if (pop)     rd_q <= rd_q + PtrW'(1);
        end
    end

endmodule

// File: tb/tb_crp16_mem_responder.sv
// Directed bench for crp16_mem_responder with hand-computed expected values.
module tb_crp16_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address_a, data_a, address_b, data_b;
    logic        wren_a, wren_b, tx_ready;
    logic [15:0] q_a, q_b, led_out, tx_data;
    logic        tx_valid;

    int checks = 0;
    int errors = 0;

    crp16_mem_responder dut (
        .clock     (clock),
        .reset     (reset),
        .address_a (address_a),
        .data_a    (data_a),
        .wren_a    (wren_a),
        .q_a       (q_a),
        .address_b (address_b),
        .data_b    (data_b),
        .wren_b    (wren_b),
        .q_b       (q_b),
        .led_out   (led_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_b(input logic [15:0] addr, input logic [15:0] data);
        address_b = addr;
        data_b    = data;
        wren_b    = 1'b1;
        tick();
        wren_b    = 1'b0;
        #1;
    endtask

    task automatic write_a(input logic [15:0] addr, input logic [15:0] data);
        address_a = addr;
        data_a    = data;
        wren_a    = 1'b1;
        tick();
        wren_a    = 1'b0;
        #1;
    endtask

    task automatic read_b(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        address_b = addr;
        #1;
        check(tag, {16'h0, q_b}, {16'h0, exp});
    endtask

    logic [15:0] drain_exp [4];

    initial begin
        reset = 1'b0; address_a = '0; data_a = '0; wren_a = 1'b0;
        address_b = '0; data_b = '0; wren_b = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("reset_led", {16'h0, led_out}, 32'h0);
        check("reset_valid", {31'h0, tx_valid}, 32'h0);
        check("reset_txdata", {16'h0, tx_data}, 32'h0);
        read_b("reset_stat", 16'hFF05, 16'h0002);

        // RAM write via port B: old data during the write cycle, new data after.
        write_a(16'h0010, 16'h0BAD);
        address_a = 16'h0010;
        address_b = 16'h0010;
        data_b    = 16'h1234;
        wren_b    = 1'b1;
        #1;
        check("ram_old_a", {16'h0, q_a}, 32'h0BAD);
        check("ram_old_b", {16'h0, q_b}, 32'h0BAD);
        tick();
        wren_b = 1'b0;
        #1;
        check("ram_new_a", {16'h0, q_a}, 32'h1234);
        check("ram_new_b", {16'h0, q_b}, 32'h1234);

        // LED write must not touch RAM index 0xF00.
        write_a(16'h0F00, 16'h7777);
        write_b(16'hFF00, 16'hBEEF);
        check("led_out", {16'h0, led_out}, 32'hBEEF);
        read_b("led_read", 16'hFF00, 16'hBEEF);
        address_a = 16'h0F00;
        #1;
        check("ram_f00_a", {16'h0, q_a}, 32'h7777);
        read_b("ram_f00_b", 16'h0F00, 16'h7777);

        // Counter: 3 reset cycles, then 10 counted edges.
        reset = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        check("led_after_reset", {16'h0, led_out}, 32'h0);
        repeat (10) @(posedge clock);
        #1;
        read_b("cnt_lo_10", 16'hFF01, 16'h000A);
        repeat (65525) @(posedge clock);
        #1;
        read_b("cnt_lo_ffff", 16'hFF01, 16'hFFFF);
        read_b("cnt_hi_0", 16'hFF02, 16'h0000);
        tick();
        read_b("cnt_lo_wrap", 16'hFF01, 16'h0000);
        read_b("cnt_hi_1", 16'hFF02, 16'h0001);
        write_b(16'hFF01, 16'h5555);
        read_b("cnt_hi_wr_ignored", 16'hFF02, 16'h0001);

        // FIFO fill and overflow with the consumer stalled.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_b(16'hFF04, 16'h0041 + 16'(i));
        read_b("stat_full", 16'hFF05, 16'h0011);
        check("head_41", {16'h0, tx_data}, 32'h41);
        check("valid_full", {31'h0, tx_valid}, 32'h1);
        write_b(16'hFF04, 16'h0045);
        read_b("stat_ovf", 16'hFF05, 16'h0091);
        check("head_stable", {16'h0, tx_data}, 32'h41);
        write_b(16'hFF05, 16'h0000);
        read_b("stat_ovf_clr", 16'hFF05, 16'h0011);

        // Push and pop together while full.
        address_b = 16'hFF04; data_b = 16'h0055; wren_b = 1'b1; tx_ready = 1'b1;
        tick();
        wren_b = 1'b0; tx_ready = 1'b0;
        #1;
        read_b("stat_pushpop", 16'hFF05, 16'h0011);
        check("head_42", {16'h0, tx_data}, 32'h42);

        drain_exp[0] = 16'h0042; drain_exp[1] = 16'h0043;
        drain_exp[2] = 16'h0044; drain_exp[3] = 16'h0055;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data%0d", i), {16'h0, tx_data}, {16'h0, drain_exp[i]});
            check($sformatf("drain_valid%0d", i), {31'h0, tx_valid}, 32'h1);
            tick();
        end
        tx_ready = 1'b0;
        #1;
        check("drained_valid", {31'h0, tx_valid}, 32'h0);
        check("drained_data", {16'h0, tx_data}, 32'h0);
        read_b("stat_empty", 16'hFF05, 16'h0002);

        // Same-index collision: port B wins.
        address_a = 16'h0020; data_a = 16'h1111; wren_a = 1'b1;
        address_b = 16'h0020; data_b = 16'h2222; wren_b = 1'b1;
        tick();
        wren_a = 1'b0; wren_b = 1'b0;
        #1;
        check("collide_a", {16'h0, q_a}, 32'h2222);
        read_b("collide_b", 16'h0020, 16'h2222);
        read_b("tx_data_rd", 16'hFF04, 16'h0000);
        read_b("unmapped_7f", 16'hFF7F, 16'h0000);

        // Reset mid-operation discards queued entries but keeps RAM.
        write_b(16'hFF04, 16'h00AA);
        write_b(16'hFF04, 16'h00BB);
        write_b(16'hFF00, 16'h00CC);
        check("pre_reset_valid", {31'h0, tx_valid}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("midreset_valid", {31'h0, tx_valid}, 32'h0);
        check("midreset_led", {16'h0, led_out}, 32'h0);
        read_b("midreset_stat", 16'hFF05, 16'h0002);
        read_b("ram_kept", 16'h0010, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
